shift_reg_seq: RTL and testbench

Parametrised multi-step shift register for the multiplication datapath. It extends the single-step load/shift register with a command interface: parallel load, logical and arithmetic shifts, and optional rotates, each by a programmable bit count. An internal counter and FSM execute one bit step per cycle, with a busy/done handshake. It is intended for the accumulator/multiplier registers of sequential Booth and shift-add multipliers, where a controller issues "shift by n" commands.

---
 rtl/shift_reg_seq.sv | 176 +++++++++++++++++
 tb/tb_shift_reg_seq.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_seq.sv
// shift_reg_seq: multi-step shift register with a command interface.
// A command (LOAD, SLL, SRL, SRA, ROL, ROR) is accepted in IDLE on start.
// Shift commands then take one bit step per cycle for the latched count,
// and a one-cycle done pulse follows the final step.
//
// Optional feature macro: SHIFT_REG_SEQ_ROTATE_EN
//   defined   -> ROL (op 100) and ROR (op 101) are implemented
//   undefined -> ops 100/101 are illegal no-ops, and no rotate logic exists
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      command request, accepted only in IDLE
//   op         000 LOAD, 001 SLL, 010 SRL, 011 SRA, 100 ROL, 101 ROR
//   amount     number of single-bit steps (clamped to WIDTH)
//   serial_in  fill bit for SLL/SRL, latched at accept
//   d          parallel load data
//   q          register contents (registered)
//   shift_out  bit expelled by the most recent step (registered)
//   busy       high while the FSM is not in IDLE (registered)
//   done       one-cycle completion pulse (registered)
module shift_reg_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [CNT_W-1:0] amount,
  input  logic             serial_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             shift_out,
  output logic             busy,
  output logic             done
);

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
`ifdef SHIFT_REG_SEQ_ROTATE_EN
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
`endif

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             shift_out_nxt;
  logic [CNT_W-1:0] count, count_nxt;
  logic [2:0]       op_r, op_nxt;
  logic             sin_r, sin_nxt;
  logic [CNT_W-1:0] amount_clamp_c;
  logic             shift_legal_c;

  // Clamp the requested step count to the register width.
  assign amount_clamp_c = (amount > CNT_MAX) ? CNT_MAX : amount;

  // Ops that run through the SHIFT state; anything else is a no-op.
  always_comb begin
    shift_legal_c = 1'b0;
    case (op)
      OP_SLL, OP_SRL, OP_SRA: shift_legal_c = 1'b1;
`ifdef SHIFT_REG_SEQ_ROTATE_EN
      OP_ROL, OP_ROR:         shift_legal_c = 1'b1;
`endif
      default:                shift_legal_c = 1'b0;
    endcase
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      q         <= '0;
      shift_out <= 1'b0;
      count     <= '0;
      op_r      <= OP_LOAD;
      sin_r     <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      q         <= q_nxt;
      shift_out <= shift_out_nxt;
      count     <= count_nxt;
      op_r      <= op_nxt;
      sin_r     <= sin_nxt;
      // busy/done registered from the next state so they track the state exactly.
      busy      <= (state_nxt != S_IDLE);
      done      <= (state_nxt == S_DONE);
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_nxt     = state;
    q_nxt         = q;
    shift_out_nxt = shift_out;
    count_nxt     = count;
    op_nxt        = op_r;
    sin_nxt       = sin_r;

    case (state)
      S_IDLE: begin
        if (start) begin
          op_nxt    = op;
          sin_nxt   = serial_in;
          count_nxt = amount_clamp_c;
          state_nxt = S_DONE;
          if (op == OP_LOAD) begin
            q_nxt         = d;
            shift_out_nxt = 1'b0;
          end else if (shift_legal_c && (amount_clamp_c != '0)) begin
            state_nxt = S_SHIFT;
          end
        end
      end

      S_SHIFT: begin
        case (op_r)
          OP_SLL: begin
            q_nxt         = {q[WIDTH-2:0], sin_r};
            shift_out_nxt = q[WIDTH-1];
          end
          OP_SRL: begin
            q_nxt         = {sin_r, q[WIDTH-1:1]};
            shift_out_nxt = q[0];
          end
          OP_SRA: begin
            q_nxt         = {q[WIDTH-1], q[WIDTH-1:1]};
            shift_out_nxt = q[0];
          end
`ifdef SHIFT_REG_SEQ_ROTATE_EN
          OP_ROL: begin
            q_nxt         = {q[WIDTH-2:0], q[WIDTH-1]};
            shift_out_nxt = q[WIDTH-1];
          end
          OP_ROR: begin
            q_nxt         = {q[0], q[WIDTH-1:1]};
            shift_out_nxt = q[0];
          end
`endif
          default: begin
            q_nxt         = q;
            shift_out_nxt = shift_out;
          end
        endcase
        count_nxt = count - CNT_ONE;
        // Leave after the step taken with count == 1 (<= guards a stray zero).
        if (count <= CNT_ONE) begin
          state_nxt = S_DONE;
        end
      end

      S_DONE: begin
        state_nxt = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_shift_reg_seq.sv
module tb_shift_reg_seq;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_SLL  = 3'b001;
  localparam logic [2:0] OP_SRL  = 3'b010;
  localparam logic [2:0] OP_SRA  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;
  localparam logic [2:0] OP_ROR  = 3'b101;
  localparam logic [2:0] OP_BAD  = 3'b111;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [2:0]       op;
  logic [CNT_W-1:0] amount;
  logic             serial_in;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] q;
  logic             shift_out;
  logic             busy;
  logic             done;

  shift_reg_seq #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .amount    (amount),
    .serial_in (serial_in),
    .d         (d),
    .q         (q),
    .shift_out (shift_out),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [WIDTH-1:0] q;
    logic             so;
    int               cyc;
    string            nm;
  } exp_t;

  exp_t             sb[$];
  exp_t             e_m;
  int               cyc = 0;
  int               n_vec = 0;
  int               n_miss = 0;
  logic [WIDTH-1:0] qs[$];
  int               busy_n;
  logic [WIDTH-1:0] rol_q;
  logic [WIDTH-1:0] zc_q;
  int               rol_lat;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Scoreboard monitor: every done pulse must match the oldest expectation.
  always @(negedge clk) begin
    cyc++;
    if (done === 1'b1) begin
      if (sb.size() == 0) begin
        chk("unexpected_done", 32'd1, 32'd0);
      end else begin
        e_m = sb.pop_front();
        chk({e_m.nm, "_q"},         32'(q),         32'(e_m.q));
        chk({e_m.nm, "_shift_out"}, 32'(shift_out), 32'(e_m.so));
        chk({e_m.nm, "_done_cycle"}, 32'(cyc),      32'(e_m.cyc));
      end
    end
  end

  // Issue one command at negedge+1 while idle, then wait for idle again.
  task automatic issue(input logic [2:0] o, input logic [CNT_W-1:0] amt, input logic s,
                       input logic [WIDTH-1:0] dd, input logic [WIDTH-1:0] eq,
                       input logic eso, input int lat, input string nm, input logic poke);
    exp_t e;
    start = 1'b1; op = o; amount = amt; serial_in = s; d = dd;
    e.q = eq; e.so = eso; e.cyc = cyc + lat; e.nm = nm;
    sb.push_back(e);
    @(negedge clk); #1;
    // Scramble command inputs after accept; the DUT must ignore them.
    start = 1'b0; serial_in = ~s; d = 8'h55; op = OP_BAD; amount = '0;
    qs.delete();
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      busy_n++;
      qs.push_back(q);
      if (poke) begin
        start = 1'b1; op = OP_LOAD; d = 8'h55;
      end
      @(negedge clk); #1;
    end
    start = 1'b0;
    if (busy) chk({nm, "_timeout"}, 32'd1, 32'd0);
    chk({nm, "_busy_len"}, 32'(busy_n), 32'(lat));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; op = OP_LOAD; amount = '0; serial_in = 1'b0; d = '0;
    #3;
    chk("rst_q",    32'(q),         32'h0);
    chk("rst_so",   32'(shift_out), 32'h0);
    chk("rst_busy", 32'(busy),      32'h0);
    chk("rst_done", 32'(done),      32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;

    // LOAD, then asynchronous reset clears q immediately.
    issue(OP_LOAD, 4'd0, 1'b0, 8'hA5, 8'hA5, 1'b0, 1, "load_a5", 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_q", 32'(q), 32'h0);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;

    // SRA by 3 on 0x96: 0xCB, 0xE5, 0xF2.
    issue(OP_LOAD, 4'd0, 1'b0, 8'h96, 8'h96, 1'b0, 1, "load_96", 1'b0);
    issue(OP_SRA, 4'd3, 1'b0, 8'h00, 8'hF2, 1'b1, 4, "sra3", 1'b0);
    if (qs.size() >= 4) begin
      chk("sra_step1", 32'(qs[1]), 32'hCB);
      chk("sra_step2", 32'(qs[2]), 32'hE5);
      chk("sra_step3", 32'(qs[3]), 32'hF2);
    end else begin
      chk("sra_steps_seen", 32'(qs.size()), 32'd4);
    end

    // SLL by 2 with serial_in=1 latched, input flipped after accept.
    issue(OP_LOAD, 4'd0, 1'b0, 8'h81, 8'h81, 1'b0, 1, "load_81a", 1'b0);
    issue(OP_SLL, 4'd2, 1'b1, 8'h00, 8'h07, 1'b0, 3, "sll2", 1'b0);

    // SRL by 12 clamps to 8; start pokes during busy are ignored.
    issue(OP_LOAD, 4'd0, 1'b0, 8'hFF, 8'hFF, 1'b0, 1, "load_ff", 1'b0);
    issue(OP_SRL, 4'd12, 1'b0, 8'h00, 8'h00, 1'b1, 9, "srl12", 1'b1);

    // ROL by 3 on 0x81.
`ifdef SHIFT_REG_SEQ_ROTATE_EN
    rol_q = 8'h0C; rol_lat = 4;
`else
    rol_q = 8'h81; rol_lat = 1;
`endif
    issue(OP_LOAD, 4'd0, 1'b0, 8'h81, 8'h81, 1'b0, 1, "load_81b", 1'b0);
    issue(OP_ROL, 4'd3, 1'b0, 8'h00, rol_q, 1'b0, rol_lat, "rol3", 1'b0);

    // Zero-count shift and illegal op leave q untouched.
    zc_q = rol_q;
    issue(OP_SLL, 4'd0, 1'b1, 8'h00, zc_q, 1'b0, 1, "sll0", 1'b0);
    issue(OP_BAD, 4'd3, 1'b1, 8'h00, zc_q, 1'b0, 1, "illegal", 1'b0);

    // ROR by full width returns the original value.
    issue(OP_LOAD, 4'd0, 1'b0, 8'h5A, 8'h5A, 1'b0, 1, "load_5a", 1'b0);
`ifdef SHIFT_REG_SEQ_ROTATE_EN
    issue(OP_ROR, 4'd8, 1'b0, 8'h00, 8'h5A, 1'b0, 9, "ror8", 1'b0);
`else
    issue(OP_ROR, 4'd8, 1'b0, 8'h00, 8'h5A, 1'b0, 1, "ror8", 1'b0);
`endif

    // Abort SRL by 5 on 0xF0 with reset in the third SHIFT cycle.
    issue(OP_LOAD, 4'd0, 1'b0, 8'hF0, 8'hF0, 1'b0, 1, "load_f0", 1'b0);
    start = 1'b1; op = OP_SRL; amount = 4'd5; serial_in = 1'b0;
    @(negedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("abort_mid_q", 32'(q), 32'h3C);
    rst_n = 1'b0;
    #1;
    chk("abort_q",    32'(q),         32'h0);
    chk("abort_busy", 32'(busy),      32'h0);
    chk("abort_so",   32'(shift_out), 32'h0);
    chk("abort_done", 32'(done),      32'h0);
    @(negedge clk); #1;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk); #1;
    issue(OP_LOAD, 4'd0, 1'b0, 8'h3C, 8'h3C, 1'b0, 1, "load_after_abort", 1'b0);

    repeat (4) @(negedge clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
